// File: rtl/hsv_to_rgb.sv
// Three-stage HSV-to-RGB converter: S1 hue split and chroma, S2 p/q/t, S3 sector mux.
// A single global enable stalls every stage together under downstream back-pressure.
module hsv_to_rgb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] h,
    input  logic [7:0] s,
    input  logic [7:0] v,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    function automatic logic [2:0] hue_sector(input logic [8:0] hn);
        if (hn >= 9'd300)      return 3'd5;
        else if (hn >= 9'd240) return 3'd4;
        else if (hn >= 9'd180) return 3'd3;
        else if (hn >= 9'd120) return 3'd2;
        else if (hn >= 9'd60)  return 3'd1;
        else                   return 3'd0;
    endfunction

    function automatic logic [8:0] sector_base(input logic [2:0] sec);
        case (sec)
            3'd1:    return 9'd60;
            3'd2:    return 9'd120;
            3'd3:    return 9'd180;
            3'd4:    return 9'd240;
            3'd5:    return 9'd300;
            default: return 9'd0;
        endcase
    endfunction

    // v - floor(C/255); the quotient never exceeds v, so 8 bits hold it.
    function automatic logic [7:0] sub_div255(input logic [7:0] val, input logic [15:0] c);
        return val - 8'(c / 16'd255);
    endfunction

    function automatic logic [7:0] sub_div15300(input logic [7:0] val, input logic [15:0] c,
                                                input logic [6:0] frac);
        logic [22:0] prod;
        prod = 23'(c) * 23'(frac);
        return val - 8'(prod / 23'd15300);
    endfunction

    logic        adv;
    logic        vld_p1_q, vld_p2_q, out_valid_q;
    logic [8:0]  hn_p1_d;
    logic [2:0]  sec_p1_d, sec_p1_q, sec_p2_q;
    logic [5:0]  f_p1_d, f_p1_q;
    logic [15:0] c_p1_d, c_p1_q;
    logic [7:0]  v_p1_q, v_p2_q;
    logic [7:0]  p_p2_d, q_p2_d, t_p2_d, p_p2_q, q_p2_q, t_p2_q;
    logic [7:0]  r_d, g_d, b_d, r_q, g_q, b_q;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;

    // S1: hue normalisation, sector/fraction split, chroma product
    always_comb begin
        hn_p1_d  = (h >= 9'd360) ? (h - 9'd360) : h;
        sec_p1_d = hue_sector(hn_p1_d);
        f_p1_d   = 6'(hn_p1_d - sector_base(sec_p1_d));
        c_p1_d   = 16'(v) * 16'(s);
    end

    // S2: p, q, t as exact floor values
    always_comb begin
        p_p2_d = sub_div255(v_p1_q, c_p1_q);
        q_p2_d = sub_div15300(v_p1_q, c_p1_q, {1'b0, f_p1_q});
        t_p2_d = sub_div15300(v_p1_q, c_p1_q, 7'd60 - {1'b0, f_p1_q});
    end

    // S3: sector mux into the output registers
    always_comb begin
        r_d = v_p2_q;
        g_d = v_p2_q;
        b_d = v_p2_q;
        case (sec_p2_q)
            3'd0: begin r_d = v_p2_q; g_d = t_p2_q; b_d = p_p2_q; end
            3'd1: begin r_d = q_p2_q; g_d = v_p2_q; b_d = p_p2_q; end
            3'd2: begin r_d = p_p2_q; g_d = v_p2_q; b_d = t_p2_q; end
            3'd3: begin r_d = p_p2_q; g_d = q_p2_q; b_d = v_p2_q; end
            3'd4: begin r_d = t_p2_q; g_d = p_p2_q; b_d = v_p2_q; end
            3'd5: begin r_d = v_p2_q; g_d = p_p2_q; b_d = q_p2_q; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
        end else if (adv) begin
            vld_p1_q    <= in_valid;
            vld_p2_q    <= vld_p1_q;
            out_valid_q <= vld_p2_q;
            if (vld_p2_q) begin
                r_q <= r_d;
                g_q <= g_d;
                b_q <= b_d;
            end
        end
    end

    // Datapath registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            sec_p1_q <= sec_p1_d;
            f_p1_q   <= f_p1_d;
            v_p1_q   <= v;
            c_p1_q   <= c_p1_d;
            sec_p2_q <= sec_p1_q;
            v_p2_q   <= v_p1_q;
            p_p2_q   <= p_p2_d;
            q_p2_q   <= q_p2_d;
            t_p2_q   <= t_p2_d;
        end
    end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// Scoreboard bench for hsv_to_rgb: directed colours, latency, stall, reset and random stream.
module tb_hsv_to_rgb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] r, g, b;

    hsv_to_rgb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .h        (h),
        .s        (s),
        .v        (v),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .r        (r),
        .g        (g),
        .b        (b)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          acc_cyc = 0;
    int          out_cyc = 0;
    logic [23:0] exp_q[$];
    logic        held_vld = 1'b0;
    logic [23:0] held_rgb = 24'd0;
    logic [23:0] last_rgb = 24'd0;

    // Reference from the floor definitions, using plain integer arithmetic.
    function automatic logic [23:0] model(input logic [8:0] hh, input logic [7:0] ss,
                                          input logic [7:0] vv);
        int hn, sec, f, c, p, q, t, vi;
        logic [7:0] p8, q8, t8;
        vi  = int'(vv);
        hn  = (int'(hh) >= 360) ? int'(hh) - 360 : int'(hh);
        sec = hn / 60;
        f   = hn % 60;
        c   = vi * int'(ss);
        p   = vi - c / 255;
        q   = vi - (c * f) / 15300;
        t   = vi - (c * (60 - f)) / 15300;
        p8  = p[7:0];
        q8  = q[7:0];
        t8  = t[7:0];
        case (sec)
            0: return {vv, t8, p8};
            1: return {q8, vv, p8};
            2: return {p8, vv, t8};
            3: return {p8, q8, vv};
            4: return {t8, p8, vv};
            default: return {vv, p8, q8};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    task automatic cycle(input logic vld, input logic [8:0] hh, input logic [7:0] ss,
                         input logic [7:0] vv, input logic ordy, output logic acc);
        in_valid  = vld;
        h         = hh;
        s         = ss;
        v         = vv;
        out_ready = ordy;
        @(negedge clk);
        if (held_vld)
            check("hold", 32'({out_valid, r, g, b}), 32'({1'b1, held_rgb}));
        if (out_valid && !out_ready)
            check("stall_rdy", 32'(in_ready), 32'd0);
        held_vld = out_valid && !out_ready;
        held_rgb = {r, g, b};
        if (out_valid && out_ready) begin
            out_cyc  = cyc;
            last_rgb = {r, g, b};
            if (exp_q.size() == 0) check("extra_out", 32'd1, 32'd0);
            else                   check("pix", 32'({r, g, b}), 32'(exp_q.pop_front()));
        end
        acc = in_valid && in_ready;
        if (acc) begin
            acc_cyc = cyc;
            exp_q.push_back(model(hh, ss, vv));
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [8:0] hh, input logic [7:0] ss,
                          input logic [7:0] vv, input logic [23:0] expc);
        logic acc;
        cycle(1'b1, hh, ss, vv, 1'b1, acc);
        check({tag, "_acc"}, 32'(acc), 32'd1);
        repeat (5) cycle(1'b0, 9'd0, 8'd0, 8'd0, 1'b1, acc);
        check(tag, 32'(last_rgb), 32'(expc));
        check({tag, "_lat"}, 32'(out_cyc - acc_cyc), 32'd3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic [23:0] rgb10;
        logic [8:0]  bp_h[6];
        int          idx;
        int          sent;

        rst_n = 1'b0; in_valid = 1'b0; h = '0; s = '0; v = '0; out_ready = 1'b1;
        #1;
        check("rst_ovld", 32'(out_valid), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        single("red",   9'd0,   8'd255, 8'd255, 24'hFF0000);
        single("green", 9'd120, 8'd255, 8'd255, 24'h00FF00);
        single("blue",  9'd240, 8'd255, 8'd255, 24'h0000FF);
        single("grey0",   9'd0,   8'd0, 8'd128, 24'h808080);
        single("grey77",  9'd77,  8'd0, 8'd128, 24'h808080);
        single("grey359", 9'd359, 8'd0, 8'd128, 24'h808080);
        single("black",   9'd200, 8'd123, 8'd0, 24'h000000);
        single("yellow",  9'd60,  8'd255, 8'd255, 24'hFFFF00);
        single("h30",     9'd30,  8'd255, 8'd200, {8'd200, 8'd100, 8'd0});
        single("h359",    9'd359, 8'd255, 8'd255, {8'd255, 8'd0, 8'd5});
        single("h10",     9'd10,  8'd200, 8'd150, model(9'd10, 8'd200, 8'd150));
        rgb10 = last_rgb;
        single("h370",    9'd370, 8'd200, 8'd150, rgb10);
        single("h511",    9'd511, 8'd180, 8'd222, model(9'd151, 8'd180, 8'd222));

        // Six back-to-back pixels with out_ready low for stream cycles 4..8.
        for (int i = 0; i < 6; i++) bp_h[i] = 9'(i * 65 + 7);
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (idx >= 6 && exp_q.size() == 0) break;
            cycle(idx < 6, (idx < 6) ? bp_h[idx] : 9'd0, 8'd200, 8'(100 + idx),
                  !(c >= 4 && c <= 8), acc);
            if (acc) idx++;
        end
        check("bp_sent", 32'(idx), 32'd6);
        check("bp_drain", 32'(exp_q.size()), 32'd0);

        // Reset with three pixels in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 9'(i * 100), 8'd255, 8'd255, 1'b1, acc);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ovld", 32'(out_valid), 32'd0);
        check("mid_rst_rgb", 32'({r, g, b}), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd1);
        exp_q.delete();
        held_vld = 1'b0;
        repeat (2) cycle(1'b1, 9'd50, 8'd99, 8'd99, 1'b1, acc);
        exp_q.delete();
        rst_n = 1'b1;
        single("post_rst", 9'd300, 8'd128, 8'd64, model(9'd300, 8'd128, 8'd64));

        // Random regression with random valid and back-pressure.
        sent = 0;
        while (sent < 10000) begin
            cycle($urandom_range(0, 3) != 0, 9'($urandom_range(0, 511)), 8'($urandom),
                  8'($urandom), $urandom_range(0, 3) != 0, acc);
            if (acc) sent++;
        end
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            cycle(1'b0, 9'd0, 8'd0, 8'd0, 1'b1, acc);
        end
        check("final_drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
